// File: rtl/four_way_tc_gf2_mul_seq.sv
// Digit-serial four-limb GF(2) polynomial multiplier with start/busy/done control.
// Ports: clk, rst (sync, active-high), start, a[N], b[N] in; busy, done, c[2N] out.
// Operands are split into four L-bit limbs; 16 limb engines consume D bits of
// each a-limb per cycle, then seven partial sums are recombined and registered
// through PIPE output stages. done pulses M+1+PIPE edges after the accepting edge.
module four_way_tc_gf2_mul_seq #(
  parameter int N    = 409,
  parameter int D    = 4,
  parameter int PIPE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] c
);

  localparam int L  = (N + 3) / 4;
  localparam int M  = (L + D - 1) / D;
  localparam int AW = 2 * L - 1;
  localparam int AX = 4 * L;
  localparam int RW = 2 * N;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int PS = (PIPE > 0) ? PIPE : 1;

  typedef enum logic [1:0] {
    IDLE, MUL, COMBINE, DRAIN
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [2:0]    dcnt;

  logic [AX-1:0] a_ext;
  logic [AX-1:0] b_ext;

  logic [L-1:0]  a_sh [4];
  logic [AW-1:0] b_sh [4];
  logic [AW-1:0] acc  [4][4];
  logic [AW-1:0] part [4][4];
  logic [AW-1:0] p    [7];
  logic [RW-1:0] r;
  logic [RW-1:0] pipe [PS];

  logic last_dig;
  logic last_pipe;

  assign a_ext = AX'(a);
  assign b_ext = AX'(b);

  assign last_dig  = (cnt == CW'(M - 1));
  assign last_pipe = (dcnt == 3'(PIPE - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MUL;
      MUL:     if (last_dig) state_nx = COMBINE;
      COMBINE: state_nx = (PIPE == 0) ? IDLE : DRAIN;
      DRAIN:   if (last_pipe) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Carry-less digit products: a_sh holds the remaining a-limb bits
  // (current digit in the low D bits), b_sh holds b_j pre-shifted by cnt*D.
  // Bits of b_sh pushed past AW can only meet digit bits beyond the limb,
  // which are zero, so truncation to AW loses nothing.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        part[i][j] = '0;
        for (int t = 0; t < D; t++) begin
          if (a_sh[i][t]) part[i][j] = part[i][j] ^ (b_sh[j] << t);
        end
      end
    end
  end

  // Seven-coefficient recombination
  always_comb begin
    for (int s = 0; s < 7; s++) begin
      p[s] = '0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          if (i + j == s) p[s] = p[s] ^ acc[i][j];
        end
      end
    end
    r = '0;
    for (int s = 0; s < 7; s++) begin
      r = r ^ (RW'(p[s]) << (s * L));
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dcnt <= '0;
      done <= 1'b0;
      c    <= '0;
      for (int k = 0; k < 4; k++) begin
        a_sh[k] <= '0;
        b_sh[k] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          acc[i][j] <= '0;
        end
      end
      for (int k = 0; k < PS; k++) pipe[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            for (int k = 0; k < 4; k++) begin
              a_sh[k] <= a_ext[k*L +: L];
              b_sh[k] <= AW'(b_ext[k*L +: L]);
            end
            for (int i = 0; i < 4; i++) begin
              for (int j = 0; j < 4; j++) begin
                acc[i][j] <= '0;
              end
            end
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          for (int k = 0; k < 4; k++) begin
            a_sh[k] <= a_sh[k] >> D;
            b_sh[k] <= b_sh[k] << D;
          end
          for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
              acc[i][j] <= acc[i][j] ^ part[i][j];
            end
          end
        end
        COMBINE: begin
          pipe[0] <= r;
          dcnt    <= '0;
          if (PIPE == 0) begin
            c    <= r;
            done <= 1'b1;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 3'd1;
          for (int k = 1; k < PS; k++) pipe[k] <= pipe[k-1];
          if (last_pipe) begin
            c    <= pipe[PS-1];
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_four_way_tc_gf2_mul_seq.sv
// Bench for four_way_tc_gf2_mul_seq: directed cases on the default build plus
// random sweeps of four parameter sets against a bit-serial carry-less model.
module tb_four_way_tc_gf2_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic          tst [5];
  logic [1023:0] ta  [5];
  logic [1023:0] tbv [5];
  logic          bz  [5];
  logic          dn  [5];
  logic [1023:0] cc  [5];

  logic bz0, bz1, bz2, bz3, bz4;
  logic dn0, dn1, dn2, dn3, dn4;
  logic [817:0] c0, c1;
  logic [465:0] c2;
  logic [325:0] c3;
  logic [13:0]  c4;

  assign bz[0] = bz0; assign bz[1] = bz1; assign bz[2] = bz2;
  assign bz[3] = bz3; assign bz[4] = bz4;
  assign dn[0] = dn0; assign dn[1] = dn1; assign dn[2] = dn2;
  assign dn[3] = dn3; assign dn[4] = dn4;
  assign cc[0] = 1024'(c0); assign cc[1] = 1024'(c1);
  assign cc[2] = 1024'(c2); assign cc[3] = 1024'(c3);
  assign cc[4] = 1024'(c4);

  four_way_tc_gf2_mul_seq #(.N(409), .D(4), .PIPE(2)) u0 (
    .clk(clk), .rst(rst), .start(tst[0]),
    .a(ta[0][408:0]), .b(tbv[0][408:0]),
    .busy(bz0), .done(dn0), .c(c0));

  four_way_tc_gf2_mul_seq #(.N(409), .D(1), .PIPE(0)) u1 (
    .clk(clk), .rst(rst), .start(tst[1]),
    .a(ta[1][408:0]), .b(tbv[1][408:0]),
    .busy(bz1), .done(dn1), .c(c1));

  four_way_tc_gf2_mul_seq #(.N(233), .D(8), .PIPE(1)) u2 (
    .clk(clk), .rst(rst), .start(tst[2]),
    .a(ta[2][232:0]), .b(tbv[2][232:0]),
    .busy(bz2), .done(dn2), .c(c2));

  four_way_tc_gf2_mul_seq #(.N(163), .D(3), .PIPE(4)) u3 (
    .clk(clk), .rst(rst), .start(tst[3]),
    .a(ta[3][162:0]), .b(tbv[3][162:0]),
    .busy(bz3), .done(dn3), .c(c3));

  four_way_tc_gf2_mul_seq #(.N(7), .D(2), .PIPE(0)) u4 (
    .clk(clk), .rst(rst), .start(tst[4]),
    .a(ta[4][6:0]), .b(tbv[4][6:0]),
    .busy(bz4), .done(dn4), .c(c4));

  int checks = 0;
  int errors = 0;

  function automatic int nw(int k);
    case (k)
      0, 1:    return 409;
      2:       return 233;
      3:       return 163;
      default: return 7;
    endcase
  endfunction

  function automatic int dw(int k);
    case (k)
      0:       return 4;
      1:       return 1;
      2:       return 8;
      3:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int pw(int k);
    case (k)
      0:       return 2;
      2:       return 1;
      3:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int lat_of(int k);
    int l, m;
    l = (nw(k) + 3) / 4;
    m = (l + dw(k) - 1) / dw(k);
    return m + 1 + pw(k);
  endfunction

  function automatic logic [1023:0] clmul(logic [1023:0] x, logic [1023:0] y, int n);
    logic [1023:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      if (x[i]) acc = acc ^ (y << i);
    end
    return acc;
  endfunction

  function automatic logic [1023:0] mask(int n);
    logic [1023:0] ones;
    ones = '1;
    return ~(ones << n);
  endfunction

  function automatic logic [1023:0] rnd(int n);
    logic [1023:0] v;
    logic [1023:0] one;
    int sel;
    one = 1024'(1);
    for (int w = 0; w < 32; w++) v[w*32 +: 32] = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 0)      v = '1;
    else if (sel == 1) v = '0;
    else if (sel == 2) v = one << $urandom_range(0, n - 1);
    return v & mask(n);
  endfunction

  task automatic chk(string tag, logic [1023:0] obs, logic [1023:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(int k, logic [1023:0] x, logic [1023:0] y);
    ta[k]  = x;
    tbv[k] = y;
    tst[k] = 1'b1;
    step();
    tst[k] = 1'b0;
  endtask

  task automatic wait_done(int k, output int lat);
    lat = 0;
    while (!dn[k] && lat < lat_of(k) + 20) begin
      step();
      lat++;
    end
  endtask

  task automatic sweep(int k, int nvec);
    logic [1023:0] x, y;
    int lat;
    for (int v = 0; v < nvec; v++) begin
      x = rnd(nw(k));
      y = rnd(nw(k));
      launch(k, x, y);
      chk($sformatf("sw%0d_busy", k), 1024'(bz[k]), 1);
      wait_done(k, lat);
      chk($sformatf("sw%0d_lat", k), lat, lat_of(k));
      chk($sformatf("sw%0d_c", k), cc[k], clmul(x, y, nw(k)));
    end
  endtask

  initial begin
    logic [1023:0] one, x1, y1, x2, y2, got, allm;
    int lat, e, nd, de;
    one = 1024'(1);
    for (int k = 0; k < 5; k++) begin
      tst[k] = 1'b0;
      ta[k]  = '0;
      tbv[k] = '0;
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle", {bz[0], dn[0], c0}, 0);
    end

    launch(0, 7, 3);
    chk("busy_up", 1024'(bz[0]), 1);
    wait_done(0, lat);
    chk("lat_7x3", lat, 29);
    chk("busy_dn", 1024'(bz[0]), 0);
    chk("c_7x3", cc[0], 9);
    step();
    chk("done_pulse", 1024'(dn[0]), 0);

    launch(0, 3, 3);
    chk("c_hold", cc[0], 9);
    wait_done(0, lat);
    chk("c_3x3", cc[0], 5);

    launch(0, one << 103, one << 306);
    wait_done(0, lat);
    chk("c_limb", cc[0], one << 409);

    launch(0, one << 408, one << 408);
    wait_done(0, lat);
    chk("c_top", cc[0], one << 816);

    allm = mask(409);
    launch(0, allm, allm);
    wait_done(0, lat);
    chk("c_ones", cc[0], clmul(allm, allm, 409));
    chk("bit817", 1024'(cc[0][817]), 0);

    x1 = rnd(409); y1 = rnd(409);
    x2 = rnd(409); y2 = rnd(409);
    launch(0, x1, y1);
    e = 0;
    repeat (6) begin step(); e++; end
    launch(0, x2, y2);
    e++;
    nd = 0; de = -1; got = '0;
    while (e < 40) begin
      step();
      e++;
      if (dn[0]) begin
        nd++;
        de = e;
        got = cc[0];
      end
    end
    chk("hs_ndone", nd, 1);
    chk("hs_lat", de, 29);
    chk("hs_c", got, clmul(x1, y1, 409));

    launch(0, x1, y1);
    wait_done(0, lat);
    chk("b2b_c1", cc[0], clmul(x1, y1, 409));
    launch(0, x2, y2);
    wait_done(0, lat);
    chk("b2b_lat", lat, 29);
    chk("b2b_c2", cc[0], clmul(x2, y2, 409));

    launch(0, x1, y1);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 1024'(bz[0]), 0);
    chk("abort_done", 1024'(dn[0]), 0);
    chk("abort_c", cc[0], 0);
    nd = 0;
    repeat (40) begin
      step();
      if (dn[0]) nd++;
    end
    chk("abort_nodone", nd, 0);
    launch(0, y2, x1);
    wait_done(0, lat);
    chk("fresh_lat", lat, 29);
    chk("fresh_c", cc[0], clmul(y2, x1, 409));

    fork
      sweep(0, 20);
      sweep(1, 500);
      sweep(2, 500);
      sweep(3, 500);
      sweep(4, 500);
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
